// File: rtl/inv_key_schedule.sv
// AES key expander feeding round keys Nr..0 to the inverse cipher; optional replay under INV_KEY_SCHEDULE_REPLAY_EN.
// Latency: 4(Nr+1)-Nk expand cycles, first key one cycle later; one key per cycle thereafter.
// Backpressure: rk_valid/rk_ready handshake, all rk_* outputs registered and held while rk_ready is low.

module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [0:255][7:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX[in_byte];
endmodule

module inv_key_schedule #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [32*Nk-1:0]  key,
    input  logic              replay,
    output logic              busy,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [127:0]      rk_data,
    output logic [3:0]        rk_round,
    output logic              rk_last
);
    localparam int WORDS = 4 * (Nr + 1);
    localparam int IW    = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

    state_t         state;
    logic [31:0]    w [WORDS];
    logic [IW-1:0]  i;
    logic [2:0]     kpos;
    logic [7:0]     rcon;
    logic [3:0]     r;

`ifdef INV_KEY_SCHEDULE_REPLAY_EN
    logic           key_loaded;
`else
    logic           unused_replay;
    assign unused_replay = replay;
`endif

    logic [31:0]    prev;
    logic [31:0]    sub_in;
    logic [31:0]    sub_out;
    logic [31:0]    temp;
    logic [31:0]    w_new;
    logic [7:0]     rcon_next;
    logic [3:0]     sel_r;
    logic [IW-1:0]  base;
    logic [127:0]   emit_word;

    // kpos tracks i mod Nk so no divider is needed for Nk=6
    always_comb begin
        prev   = w[i - IW'(1)];
        sub_in = (kpos == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        temp   = prev;
        if (kpos == 3'd0)
            temp = sub_out ^ {rcon, 24'h0};
        else if (Nk == 8 && kpos == 3'd4)
            temp = sub_out;
        w_new  = w[i - IW'(Nk)] ^ temp;
    end

    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);

    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (
            .in_byte  (sub_in[8*b +: 8]),
            .out_byte (sub_out[8*b +: 8])
        );
    end

    // Round whose key is loaded into rk_data on this edge
    always_comb begin
        sel_r = r;
        if (state == IDLE)
            sel_r = 4'(Nr);
        else if (rk_valid && r != 4'd0)
            sel_r = r - 4'd1;
    end

    assign base      = IW'({sel_r, 2'b00});
    assign emit_word = {w[base], w[base + IW'(1)], w[base + IW'(2)], w[base + IW'(3)]};

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            for (int k = 0; k < Nk; k++)
                w[IW'(k)] <= key[32*(Nk-1-k) +: 32];
        end else if (state == EXPAND) begin
            w[i] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_round <= '0;
            rk_last  <= 1'b0;
            i        <= '0;
            kpos     <= '0;
            rcon     <= 8'h01;
            r        <= '0;
`ifdef INV_KEY_SCHEDULE_REPLAY_EN
            key_loaded <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= EXPAND;
                        busy  <= 1'b1;
                        i     <= IW'(Nk);
                        kpos  <= '0;
                        rcon  <= 8'h01;
                    end
`ifdef INV_KEY_SCHEDULE_REPLAY_EN
                    else if (replay && key_loaded) begin
                        state    <= EMIT;
                        busy     <= 1'b1;
                        r        <= 4'(Nr);
                        rk_valid <= 1'b1;
                        rk_data  <= emit_word;
                        rk_round <= 4'(Nr);
                        rk_last  <= 1'b0;
                    end
`endif
                end
                EXPAND: begin
                    i    <= i + IW'(1);
                    kpos <= (kpos == 3'(Nk - 1)) ? 3'd0 : kpos + 3'd1;
                    if (kpos == 3'd0)
                        rcon <= rcon_next;
                    if (i == IW'(WORDS - 1)) begin
                        state <= EMIT;
                        r     <= 4'(Nr);
`ifdef INV_KEY_SCHEDULE_REPLAY_EN
                        key_loaded <= 1'b1;
`endif
                    end
                end
                EMIT: begin
                    // First EMIT cycle primes the output register from the finished array
                    if (!rk_valid) begin
                        rk_valid <= 1'b1;
                        rk_data  <= emit_word;
                        rk_round <= r;
                        rk_last  <= (r == 4'd0);
                    end else if (rk_ready) begin
                        if (r == 4'd0) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            rk_valid <= 1'b0;
                            rk_last  <= 1'b0;
                        end else begin
                            r        <= r - 4'd1;
                            rk_data  <= emit_word;
                            rk_round <= r - 4'd1;
                            rk_last  <= (r == 4'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: AES-128 and AES-256 instances on a shared clock.
module tb_inv_key_schedule;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         start, replay, rk_ready;
    logic [127:0] key;
    logic         busy, rk_valid, rk_last;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;

    logic         start8, replay8, rk_ready8;
    logic [255:0] key8;
    logic         busy8, rk_valid8, rk_last8;
    logic [127:0] rk_data8;
    logic [3:0]   rk_round8;

    int vectors = 0;
    int errors  = 0;
    logic [127:0] fips_rk [11];

    inv_key_schedule #(.Nk(4), .Nr(10)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key(key), .replay(replay),
        .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
        .rk_round(rk_round), .rk_last(rk_last)
    );

    inv_key_schedule #(.Nk(8), .Nr(14)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .key(key8), .replay(replay8),
        .busy(busy8), .rk_valid(rk_valid8), .rk_ready(rk_ready8), .rk_data(rk_data8),
        .rk_round(rk_round8), .rk_last(rk_last8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 0; replay = 0; rk_ready = 0; key = '0;
        start8 = 0; replay8 = 0; rk_ready8 = 0; key8 = '0;
        #12;
        vectors++;
        if ({busy, rk_valid, rk_last} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: busy/valid/last=%b expected 000", {busy, rk_valid, rk_last});
        end
        vectors++;
        if (rk_data !== 128'h0 || rk_round !== 4'd0) begin
            errors++; $display("FAIL reset_data: data=%h round=%0d expected 0/0", rk_data, rk_round);
        end
        tick();
        reset_n = 1'b1;
        tick();
        replay = 1'b1;
        tick();
        replay = 1'b0;
        repeat (3) begin
            vectors++;
            if (rk_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL replay_unloaded: valid=%b busy=%b expected 0/0", rk_valid, busy);
            end
            tick();
        end
    endtask

    task automatic test_fips128();
        int n;
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || rk_valid !== 1'b0) begin
            errors++; $display("FAIL start_busy: busy=%b valid=%b expected 1/0", busy, rk_valid);
        end
        n = 0;
        while (!rk_valid && n < 200) begin tick(); n++; end
        vectors++;
        if (n != 41) begin
            errors++; $display("FAIL latency128: got %0d cycles expected 41", n);
        end
        for (int k = 10; k >= 0; k--) begin
            vectors++;
            if (rk_round !== 4'(k) || rk_data !== fips_rk[k] || rk_last !== (k == 0)) begin
                errors++;
                $display("FAIL stream128_r%0d: round=%0d data=%h last=%b expected %0d %h %b",
                         k, rk_round, rk_data, rk_last, k, fips_rk[k], (k == 0));
            end
            tick();
        end
        vectors++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            errors++; $display("FAIL done128: busy=%b valid=%b expected 0/0", busy, rk_valid);
        end
    endtask

    task automatic test_replay();
        replay = 1'b1;
        tick();
        replay = 1'b0;
`ifdef INV_KEY_SCHEDULE_REPLAY_EN
        for (int k = 10; k >= 0; k--) begin
            vectors++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(k) || rk_data !== fips_rk[k] || rk_last !== (k == 0)) begin
                errors++;
                $display("FAIL replay_r%0d: valid=%b round=%0d data=%h last=%b expected 1 %0d %h %b",
                         k, rk_valid, rk_round, rk_data, rk_last, k, fips_rk[k], (k == 0));
            end
            tick();
        end
        vectors++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            errors++; $display("FAIL replay_done: busy=%b valid=%b expected 0/0", busy, rk_valid);
        end
`else
        repeat (3) begin
            vectors++;
            if (rk_valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL replay_disabled: valid=%b busy=%b expected 0/0", rk_valid, busy);
            end
            tick();
        end
`endif
    endtask

    task automatic test_backpressure();
        int n, exp_r, xfers, cyc;
        logic stalled;
        logic [127:0] held;
        rk_ready = 1'b0;
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!rk_valid && n < 200) begin tick(); n++; end
        exp_r = 10; xfers = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (xfers < 11 && cyc < 400) begin
            vectors++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(exp_r) || rk_data !== fips_rk[exp_r]) begin
                errors++;
                $display("FAIL bp_key cyc%0d: valid=%b round=%0d data=%h expected 1 %0d %h",
                         cyc, rk_valid, rk_round, rk_data, exp_r, fips_rk[exp_r]);
            end
            if (stalled) begin
                vectors++;
                if (rk_data !== held) begin
                    errors++; $display("FAIL bp_hold cyc%0d: data=%h held=%h", cyc, rk_data, held);
                end
            end
            rk_ready = ($urandom_range(0, 2) != 0);
            if (cyc == 5) begin
                start = 1'b1;
                key = 128'hffeeddccbbaa99887766554433221100;
            end else begin
                start = 1'b0;
            end
            stalled = !rk_ready;
            held = rk_data;
            if (rk_ready) begin xfers++; exp_r--; end
            tick();
            cyc++;
        end
        start = 1'b0;
        vectors++;
        if (xfers != 11) begin
            errors++; $display("FAIL bp_count: got %0d transfers expected 11", xfers);
        end
        vectors++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            errors++; $display("FAIL bp_done: busy=%b valid=%b expected 0/0", busy, rk_valid);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        key = 128'h000102030405060708090a0b0c0d0e0f;
        rk_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: busy=%b expected 1", busy);
        end
        n = 0;
        while (!rk_valid && n < 200) begin tick(); n++; end
        vectors++;
        if (n != 41 || rk_round !== 4'd10 || rk_data !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
            errors++;
            $display("FAIL b2b_r10: cycles=%0d round=%0d data=%h expected 41 10 13111d7fe3944a17f307a78b4d2b30c5",
                     n, rk_round, rk_data);
        end
        repeat (10) tick();
        vectors++;
        if (rk_round !== 4'd0 || rk_last !== 1'b1 || rk_data !== 128'h000102030405060708090a0b0c0d0e0f) begin
            errors++; $display("FAIL b2b_r0: round=%0d last=%b data=%h expected 0 1 key", rk_round, rk_last, rk_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_expand();
        int n;
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        vectors++;
        if (busy !== 1'b1 || rk_valid !== 1'b0) begin
            errors++; $display("FAIL mid_expand: busy=%b valid=%b expected 1/0", busy, rk_valid);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({busy, rk_valid, rk_last} !== 3'b000 || rk_data !== 128'h0 || rk_round !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: busy/valid/last=%b data=%h round=%0d expected 000 0 0",
                     {busy, rk_valid, rk_last}, rk_data, rk_round);
        end
        #2;
        reset_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!rk_valid && n < 200) begin tick(); n++; end
        vectors++;
        if (n != 41 || rk_data !== fips_rk[10]) begin
            errors++; $display("FAIL post_reset_r10: cycles=%0d data=%h expected 41 %h", n, rk_data, fips_rk[10]);
        end
        repeat (9) tick();
        vectors++;
        if (rk_round !== 4'd1 || rk_data !== fips_rk[1]) begin
            errors++; $display("FAIL post_reset_r1: round=%0d data=%h expected 1 %h", rk_round, rk_data, fips_rk[1]);
        end
        repeat (2) tick();
    endtask

    task automatic test_aes256();
        int n;
        key8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        rk_ready8 = 1'b1;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!rk_valid8 && n < 200) begin tick(); n++; end
        vectors++;
        if (n != 53) begin
            errors++; $display("FAIL latency256: got %0d cycles expected 53", n);
        end
        vectors++;
        if (rk_round8 !== 4'd14 || rk_data8 !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
            errors++; $display("FAIL aes256_r14: round=%0d data=%h expected 14 24fc79ccbf0979e9371ac23c6d68de36",
                               rk_round8, rk_data8);
        end
        repeat (13) tick();
        vectors++;
        if (rk_round8 !== 4'd1 || rk_data8 !== 128'h101112131415161718191a1b1c1d1e1f) begin
            errors++; $display("FAIL aes256_r1: round=%0d data=%h expected 1 101112131415161718191a1b1c1d1e1f",
                               rk_round8, rk_data8);
        end
        tick();
        vectors++;
        if (rk_round8 !== 4'd0 || rk_last8 !== 1'b1 || rk_data8 !== 128'h000102030405060708090a0b0c0d0e0f) begin
            errors++; $display("FAIL aes256_r0: round=%0d last=%b data=%h expected 0 1 000102030405060708090a0b0c0d0e0f",
                               rk_round8, rk_last8, rk_data8);
        end
        tick();
        vectors++;
        if (busy8 !== 1'b0 || rk_valid8 !== 1'b0) begin
            errors++; $display("FAIL aes256_done: busy=%b valid=%b expected 0/0", busy8, rk_valid8);
        end
    endtask

    initial begin
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        test_reset();
        test_fips128();
        test_replay();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_expand();
        test_aes256();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

Sequential AES key expander and reverse-order round-key source for the decryption datapath. It accepts a cipher key of Nk words and expands it one word per cycle into an internal buffer of 4·(Nr+1) words. It then streams the round keys from round Nr down to round 0, one 128-bit key per valid/ready handshake. It sits directly upstream of the inverse round stage and supplies the key for each inverse round.

## Interface
- `Nk`, default 4: key length in 32-bit words. Legal values are 4, 6 and 8.
- `Nr`, default 10: number of rounds. Must equal Nk+6.
- `clk`  input  1: single clock. All state changes on the rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: single-cycle pulse that requests expansion of `key`. Sampled only in IDLE.
- `key`  input  32·Nk: cipher key. Word 0 is in the MSBs (FIPS-197 byte order).
- `replay`  input  1: re-emit the stored schedule without re-expanding. See Configuration.
- `busy`  output  1: high in EXPAND and EMIT.
- `rk_valid`  output  1: `rk_data` holds a valid round key.
- `rk_ready`  input  1: consumer accepts the round key.
- `rk_data`  output  128: round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in the MSBs.
- `rk_round`  output  4: round index r of `rk_data`.
- `rk_last`  output  1: high while r==0 is presented.

## Operation
- Storage: register array w[0 .. 4(Nr+1)−1] of 32-bit words, a word index i, a round counter r, and an Rcon byte register.
- Reset values: state=IDLE, busy=0, rk_valid=0, rk_data=0, rk_round=0, rk_last=0, i=0, Rcon=8'h01. The word array is not reset.
- IDLE:
  - On `start`: load w[0..Nk−1] from `key`, set i=Nk, set Rcon=8'h01, go to EXPAND.
- EXPAND: writes one word per cycle.
  - temp = w[i−1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {Rcon, 24'h0}, then Rcon = xtime(Rcon), with reduction polynomial 8'h1B.
  - Else if Nk==8 and i mod Nk == 4: temp = SubWord(temp).
  - w[i] = w[i−Nk] ^ temp, then i = i+1.
  - After writing w[4(Nr+1)−1]: set r=Nr and go to EMIT.
  - SubWord uses four instances of the codebase's forward S-box.
- EMIT:
  - `rk_valid`=1; `rk_data`, `rk_round` and `rk_last` reflect the current r.
  - On `rk_valid && rk_ready`: if r==0, go to IDLE (rk_valid drops the next cycle); otherwise r = r−1.
  - While `rk_ready`=0, all rk_* outputs hold stable.
- `start` outside IDLE is ignored. `key` is captured only at the accepted `start`.
- If `start` and `replay` are both high in IDLE, `start` wins.
- Asserting `reset_n` low in any state returns immediately to IDLE with the reset output values. Any partially expanded schedule is discarded.

## Timing
- EXPAND lasts 4(Nr+1)−Nk cycles: 40 for AES-128, 46 for AES-192, 52 for AES-256.
- If `start` is sampled at edge 0, `busy`=1 after edge 0.
- The first `rk_valid` is high after edge 4(Nr+1)−Nk+1. For AES-128 that is after edge 41.
- With `rk_ready` held at 1, one key transfers per cycle: Nr+1 consecutive transfers, then `busy`=0 on the cycle after the round-0 transfer.
- Earliest back-to-back `start` acceptance is the first cycle in which IDLE is re-entered.
- All outputs are registered. There is no combinational path from `rk_ready` to `rk_data`.

## Configuration
- `INV_KEY_SCHEDULE_REPLAY_EN` defined:
  - A `key_loaded` flag is set when EXPAND completes and cleared by reset.
  - In IDLE, `replay` with `key_loaded`=1 goes directly to EMIT with r=Nr, with no expansion (this serves multi-block decryption under one key). `rk_valid` rises the cycle after `replay` is sampled.
  - `replay` with `key_loaded`=0 is ignored.
  - A new `start` re-expands and overwrites the stored schedule.
- Not defined: `replay` is ignored in every state and `key_loaded` is not built. Every key stream requires `start`.

## Test plan
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1 → first `rk_valid` 41 cycles after `start`.
  - r=10: d014f9a8c9ee2589e13f0cc8b6630ca6.
  - r=1: a0fafe1788542cb123a339392a6c7605.
  - r=0: the key itself, with `rk_last`=1.
- AES-128 key 000102030405060708090a0b0c0d0e0f → r=10 key 13111d7fe3944a17f307a78b4d2b30c5.
- Nk=8, Nr=14, key 00010203…1e1f → r=14 key 24fc79ccbf0979e9371ac23c6d68de36; EXPAND lasts 52 cycles.
- Randomized `rk_ready` backpressure → `rk_data` and `rk_round` stable while stalled, no round skipped or repeated, exactly Nr+1 transfers. A `start` pulse issued mid-EMIT is ignored.
- `reset_n` driven low at EXPAND cycle 20 → all outputs at reset values asynchronously; a fresh `start` produces the correct schedule.
- With `INV_KEY_SCHEDULE_REPLAY_EN` defined: complete one stream, then `replay` → identical 11-key stream beginning one cycle later. `replay` issued after reset and before any `start` → no response.
